// File: rtl/dsec_pkg.sv
// Shared types and constants for the dsec output path.
// Word/byte geometry and the serializer FSM encoding.
package dsec_pkg;

  localparam int WORD_W         = 64;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 8;
  localparam int ENTRY_W        = WORD_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  typedef struct packed {
    logic              err;
    logic [WORD_W-1:0] word;
  } fifo_entry_t;

endpackage

// File: rtl/dsec_out_serializer_if.sv
// Word-in / byte-out handshake bundle of the serializer.
// slave = serializer side, master = environment side.
interface dsec_out_serializer_if
  import dsec_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] data_in;
  logic              in_valid;
  logic              error_in;
  logic              out_rcvd;
  logic [BYTE_W-1:0] byte_out;
  logic              byte_valid;
  logic              byte_ready;
  logic              byte_last;
  logic              err_flag;
  logic [CNT_W-1:0]  fifo_count;

  modport slave (
    input  data_in,
    input  in_valid,
    input  error_in,
    input  byte_ready,
    output out_rcvd,
    output byte_out,
    output byte_valid,
    output byte_last,
    output err_flag,
    output fifo_count
  );

  modport master (
    output data_in,
    output in_valid,
    output error_in,
    output byte_ready,
    input  out_rcvd,
    input  byte_out,
    input  byte_valid,
    input  byte_last,
    input  err_flag,
    input  fifo_count
  );

endinterface

// File: rtl/dsec_sync_fifo.sv
// Single-clock FIFO holding a tagged word per entry.
// count spans 0..DEPTH so full and empty never alias.
module dsec_sync_fifo
  import dsec_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int W     = ENTRY_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  // power-of-two depth: natural pointer overflow is the wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/dsec_out_serializer.sv
// Buffers tagged 64-bit dsec words and emits them MSB byte first.
// Back-to-back words stream without a bubble at word boundaries.
module dsec_out_serializer
  import dsec_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  dsec_out_serializer_if.slave io
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int KW = $clog2(BYTES_PER_WORD);
  localparam logic [KW-1:0] LAST_K =
    KW'(BYTES_PER_WORD - 1);

  ser_state_e        state;
  ser_state_e        state_nx;
  logic [WORD_W-1:0] shreg;
  logic              tag;
  logic [KW-1:0]     k;
  logic              rcvd_q;
  logic              capture;
  logic              xfer;
  logic              at_last;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  fifo_entry_t       wr_entry;
  fifo_entry_t       head;
  logic [ENTRY_W-1:0] head_raw;

  // rcvd_q gates capture so dsec sees one pulse per word
  assign capture  = io.in_valid & ~full & ~rcvd_q;
  assign wr_entry = '{err: io.error_in, word: io.data_in};
  assign head     = fifo_entry_t'(head_raw);
  assign xfer     = (state == SEND) & io.byte_ready;
  assign at_last  = (k == LAST_K);
  assign pop      = ~empty &
                    ((state == IDLE) | (xfer & at_last));

  dsec_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head_raw),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rcvd_q <= 1'b0;
    else      rcvd_q <= capture;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == IDLE:
        if (!empty) state_nx = SEND;
      state == SEND:
        if (xfer && at_last && empty)
          state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      tag   <= 1'b0;
      k     <= '0;
    end else if (pop) begin
      shreg <= head.word;
      tag   <= head.err;
      k     <= '0;
    end else if (xfer) begin
      shreg <= shreg << BYTE_W;
      k     <= k + 1'b1;
    end
  end

  always_comb begin
    io.byte_valid = 1'b0;
    io.byte_out   = '0;
    io.byte_last  = 1'b0;
    io.err_flag   = 1'b0;
    if (state == SEND) begin
      io.byte_valid = 1'b1;
      io.byte_out   = shreg[WORD_W-1 -: BYTE_W];
      io.byte_last  = at_last;
      io.err_flag   = tag;
    end
  end

  assign io.out_rcvd   = rcvd_q;
  assign io.fifo_count = count;

endmodule

// File: tb/tb_dsec_out_serializer.sv
// Scoreboard bench for dsec_out_serializer.
// Offered words expand into an expected byte queue; a monitor pops it.
module tb_dsec_out_serializer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] b;
    logic       last;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int   n_chk    = 0;
  int   n_fail   = 0;
  int   rcvd_cnt = 0;
  int   nx       = 0;
  int   rmode    = 3;
  int   ph       = 0;
  logic busy     = 1'b0;
  logic nogap    = 1'b0;

  exp_t        q[$];
  logic [64:0] wq[$];
  logic [64:0] drv_e;
  exp_t        mx;
  logic        pv_stall;
  logic [7:0]  pv_b;
  logic        pv_l;
  logic        pv_e;

  dsec_out_serializer_if #(.DEPTH(DEPTH)) bus ();

  dsec_out_serializer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h",
               name, act, exp);
    end
  endtask

  // word driver: holds in_valid until the out_rcvd pulse
  initial begin
    bus.data_in  = '0;
    bus.error_in = 1'b0;
    bus.in_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        busy         = 1'b0;
        bus.in_valid = 1'b0;
      end else begin
        if (bus.out_rcvd) begin
          chk("rcvd_while_offered", 64'(busy), 1);
          rcvd_cnt++;
          busy = 1'b0;
        end
        if (!busy && wq.size() > 0) begin
          drv_e = wq.pop_front();
          bus.data_in  = drv_e[63:0];
          bus.error_in = drv_e[64];
          bus.in_valid = 1'b1;
          busy         = 1'b1;
          for (int k = 0; k < 8; k++)
            q.push_back('{b:    drv_e[63-8*k -: 8],
                          last: (k == 7),
                          err:  drv_e[64]});
        end else if (!busy) begin
          bus.in_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    bus.byte_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       bus.byte_ready = 1'b1;
        1:       bus.byte_ready = (ph % 4 == 0) ||
                                  (ph % 4 == 3);
        2:       bus.byte_ready = 1'($urandom_range(0, 1));
        default: bus.byte_ready = 1'b0;
      endcase
      ph++;
    end
  end

  initial begin
    pv_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pv_stall = 1'b0;
      end else begin
        if (pv_stall) begin
          chk("hold_valid", 64'(bus.byte_valid), 1);
          chk("hold_byte", 64'(bus.byte_out), 64'(pv_b));
          chk("hold_last", 64'(bus.byte_last), 64'(pv_l));
          chk("hold_err", 64'(bus.err_flag), 64'(pv_e));
        end
        if (nogap && bus.byte_ready && q.size() > 0)
          chk("no_gap", 64'(bus.byte_valid), 1);
        if (!bus.byte_valid) begin
          chk("idle_last", 64'(bus.byte_last), 0);
          chk("idle_err", 64'(bus.err_flag), 0);
        end else if (bus.byte_ready) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL extra_byte: got %0h, none expected",
                     bus.byte_out);
          end else begin
            mx = q.pop_front();
            chk("byte", 64'(bus.byte_out), 64'(mx.b));
            chk("last", 64'(bus.byte_last), 64'(mx.last));
            chk("err", 64'(bus.err_flag), 64'(mx.err));
          end
          nx++;
        end
        pv_stall = bus.byte_valid & ~bus.byte_ready;
        pv_b     = bus.byte_out;
        pv_l     = bus.byte_last;
        pv_e     = bus.err_flag;
      end
    end
  end

  task automatic drain(input int budget, input string name);
    int i;
    i = 0;
    while ((q.size() > 0 || wq.size() > 0 || busy)
           && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, 64'(i < budget), 1);
    repeat (3) @(negedge clk);
    chk({name, "_idle"}, 64'(bus.byte_valid), 0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_rcvd"}, 64'(bus.out_rcvd), 0);
    chk({name, "_valid"}, 64'(bus.byte_valid), 0);
    chk({name, "_byte"}, 64'(bus.byte_out), 0);
    chk({name, "_last"}, 64'(bus.byte_last), 0);
    chk({name, "_err"}, 64'(bus.err_flag), 0);
    chk({name, "_count"}, 64'(bus.fifo_count), 0);
  endtask

  initial begin
    int  base;
    int  n0;
    int  i;
    bit  ok;

    #3;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // single word, latency and order
    rmode = 0;
    base  = rcvd_cnt;
    wq.push_back({1'b0, 64'h0123456789ABCDEF});
    ok = 0;
    for (int j = 0; j < 50 && !ok; j++) begin
      @(posedge clk); #2;
      if (bus.out_rcvd) ok = 1;
    end
    chk("single_rcvd_seen", 64'(ok), 1);
    chk("lat_cap_valid", 64'(bus.byte_valid), 0);
    chk("lat_cap_count", 64'(bus.fifo_count), 1);
    @(posedge clk); #2;
    chk("lat_load_valid", 64'(bus.byte_valid), 1);
    chk("lat_load_byte", 64'(bus.byte_out), 64'h01);
    chk("lat_load_rcvd", 64'(bus.out_rcvd), 0);
    chk("lat_load_count", 64'(bus.fifo_count), 0);
    nogap = 1'b1;
    drain(100, "single");
    nogap = 1'b0;
    chk("single_rcvd_once", 64'(rcvd_cnt - base), 1);

    // back-pressure 1,0,0,1
    rmode = 1;
    wq.push_back({1'b0, 32'($urandom), 32'($urandom)});
    wq.push_back({1'b0, 32'($urandom), 32'($urandom)});
    drain(300, "bp");

    // full FIFO with a stalled sink
    rmode = 3;
    base  = rcvd_cnt;
    for (int j = 0; j < 6; j++)
      wq.push_back({1'b0, 32'($urandom), 32'($urandom)});
    repeat (30) @(posedge clk);
    #2;
    chk("full_accepted", 64'(rcvd_cnt - base), 5);
    chk("full_count", 64'(bus.fifo_count), 4);
    chk("full_valid", 64'(bus.byte_valid), 1);
    chk("full_head", 64'(bus.byte_out), 64'(q[0].b));
    n0    = nx;
    nogap = 1'b1;
    rmode = 0;
    drain(300, "full_drain");
    nogap = 1'b0;
    chk("full_bytes", 64'(nx - n0), 48);
    chk("full_rcvd", 64'(rcvd_cnt - base), 6);

    // error tag on the first word only
    rmode = 0;
    wq.push_back({1'b1, 64'hDEAD_BEEF_0000_0001});
    wq.push_back({1'b0, 32'($urandom), 32'($urandom)});
    drain(200, "errtag");

    // random traffic and random sink
    rmode = 2;
    for (int j = 0; j < 20; j++)
      wq.push_back({1'($urandom_range(0, 1)),
                    32'($urandom), 32'($urandom)});
    drain(3000, "random");

    // reset after byte 3 of word 2 of 3
    rmode = 0;
    n0    = nx;
    for (int j = 0; j < 3; j++)
      wq.push_back({1'b0, 32'($urandom), 32'($urandom)});
    i = 0;
    while (nx - n0 < 12 && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk("rst_reach", 64'(i < 300), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("midrst");
    q.delete();
    wq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk); #1;
      chk("post_rst_valid", 64'(bus.byte_valid), 0);
    end
    chk("post_rst_count", 64'(bus.fifo_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no end, want finish");
    $fatal(1);
  end

endmodule
